// File: rtl/lpm_bipad_ctrl_pkg.sv
// Shared definitions for the lpm_bipad sequencing controller: controller
// state encoding and the helper that sizes the phase counter.
package lpm_bipad_ctrl_pkg;

    // Controller states; encodings are fixed so debug tooling can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } ctrl_state_e;

    // Counter width: clog2 of the largest phase length, plus one bit of
    // headroom so a full-length load always fits without wrapping.
    function automatic int cnt_width(
        input int wr_cycles,
        input int rd_wait,
        input int turn_cycles
    );
        int largest;
        largest = wr_cycles;
        largest = (rd_wait > largest) ? rd_wait : largest;
        largest = (turn_cycles > largest) ? turn_cycles : largest;
        largest = (largest < 1) ? 1 : largest;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/lpm_bipad_ctrl_timer.sv
// Loadable down-counter that times each controller phase.  A load takes
// priority over counting; once at zero the counter holds there, so it never
// wraps.  zero_o is decoded straight from the counter register.
module lpm_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             sclr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise step down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lpm_bipad_ctrl.sv
// Sequencing controller placed in front of lpm_bipad.  Single-cycle
// write/read requests become timed pad cycles: a drive phase with enable
// high, a read phase with the pad released until the result is sampled, and
// a turnaround gap so the pad is never driven while an external device may
// still be driving it.  The FSM and all datapath registers live here; phase
// lengths come from one shared down-counter.
module lpm_bipad_ctrl
    import lpm_bipad_ctrl_pkg::*;
#(
    parameter int lpm_width       = 1,
    parameter int lpm_wr_cycles   = 2,
    parameter int lpm_rd_wait     = 2,
    parameter int lpm_turn_cycles = 1,
    parameter     lpm_hint        = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 wr_req,
    input  logic [lpm_width-1:0] wr_data,
    input  logic                 rd_req,
    output logic                 ready,
    output logic [lpm_width-1:0] rd_data,
    output logic                 rd_valid,
    output logic [lpm_width-1:0] data,
    output logic                 enable,
    input  logic [lpm_width-1:0] result
);

    localparam int CNT_W = cnt_width(lpm_wr_cycles, lpm_rd_wait, lpm_turn_cycles);

    // Counter load values; each phase lasts (load value + 1) cycles.
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(lpm_wr_cycles - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(lpm_rd_wait - 1);
    localparam bit               HAS_TURN  = (lpm_turn_cycles > 0);
    localparam logic [CNT_W-1:0] TURN_LOAD = HAS_TURN ? CNT_W'(lpm_turn_cycles - 1) : '0;

    // The hint is informational only and selects no hardware.
    if ($bits(lpm_hint) == 0) begin : g_hint_empty
    end

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic [lpm_width-1:0] data_q;
    logic [lpm_width-1:0] data_d;
    logic                 enable_q;
    logic                 enable_d;
    logic [lpm_width-1:0] rd_data_q;
    logic [lpm_width-1:0] rd_data_d;
    logic                 rd_valid_q;
    logic                 rd_valid_d;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_zero;

    logic                 ready_int;
    logic                 accept_wr;
    logic                 accept_rd;

    // Requests are taken only in IDLE and never while the clear is active;
    // a simultaneous write wins and the read is dropped.
    assign ready_int = (state_q == ST_IDLE) & ~sclr;
    assign accept_wr = ready_int & wr_req;
    assign accept_rd = ready_int & ~wr_req & rd_req;

    lpm_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clock),
        .sclr_i     (sclr),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    // State and datapath registers; the clear aborts any phase immediately.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            enable_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            enable_q   <= enable_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state: phases end when the timer reaches zero; TURN is skipped
    // entirely when no turnaround is configured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_wr) begin
                    state_d = ST_WRITE;
                end else if (accept_rd) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (tmr_zero) begin
                    state_d = HAS_TURN ? ST_TURN : ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_TURN: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TURN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values and timer loads for each state.
    always_comb begin
        data_d       = data_q;
        enable_d     = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_wr) begin
                    data_d       = wr_data;
                    enable_d     = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = WR_LOAD;
                end else if (accept_rd) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RD_LOAD;
                end else begin
                    enable_d     = 1'b0;
                end
            end
            ST_WRITE: begin
                if (tmr_zero) begin
                    enable_d     = 1'b0;
                    tmr_load     = HAS_TURN;
                    tmr_load_val = TURN_LOAD;
                end else begin
                    enable_d     = 1'b1;
                end
            end
            ST_READ: begin
                if (tmr_zero) begin
                    rd_data_d    = result;
                    rd_valid_d   = 1'b1;
                    tmr_load     = HAS_TURN;
                    tmr_load_val = TURN_LOAD;
                end else begin
                    rd_valid_d   = 1'b0;
                end
            end
            ST_TURN: begin
                enable_d = 1'b0;
            end
            default: begin
                enable_d = 1'b0;
            end
        endcase
    end

    assign ready    = ready_int;
    assign data     = data_q;
    assign enable   = enable_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lpm_bipad_ctrl.sv
// Bench for lpm_bipad_ctrl (width 8, 2 write cycles, 2 read-wait cycles,
// 1 turnaround cycle).  The reference model works in absolute cycle numbers:
// each accepted request books a drive window, an external-drive window, a
// ready time and (for reads) an expected rd_valid entry in a scoreboard
// queue.  A separate monitor compares the DUT against these on every
// falling edge.
module tb_lpm_bipad_ctrl;

    localparam int W   = 8;
    localparam int WRC = 2;
    localparam int RDW = 2;
    localparam int TC  = 1;

    logic         clock    = 1'b0;
    logic         sclr     = 1'b1;
    logic         wr_req   = 1'b0;
    logic [W-1:0] wr_data  = 8'h00;
    logic         rd_req   = 1'b0;
    logic         ready;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [W-1:0] data;
    logic         enable;
    logic [W-1:0] result;
    logic [W-1:0] ext_val  = 8'h00;

    always #5 clock = ~clock;

    lpm_bipad_ctrl #(
        .lpm_width       (W),
        .lpm_wr_cycles   (WRC),
        .lpm_rd_wait     (RDW),
        .lpm_turn_cycles (TC),
        .lpm_hint        ("UNUSED")
    ) dut (
        .clock    (clock),
        .sclr     (sclr),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .ready    (ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .data     (data),
        .enable   (enable),
        .result   (result)
    );

    // Pad model: the controller's data when it drives, otherwise the
    // external device's value.
    assign result = enable ? data : ext_val;

    // Cycle number: cycle k is the interval after the k-th rising edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
    } rd_exp_t;

    rd_exp_t      rq[$];
    int           ready_from = 0;
    int           en_lo      = 1;
    int           en_hi      = 0;
    int           ext_lo     = 1;
    int           ext_hi     = 0;
    logic [W-1:0] data_model = 8'h00;
    logic         exp_ready  = 1'b0;
    logic         exp_en     = 1'b0;
    logic         exp_ext    = 1'b0;
    logic [W-1:0] exp_data   = 8'h00;
    bit           started    = 1'b0;
    bit           done       = 1'b0;

    // One cycle of stimulus; also records the expected outputs for this
    // cycle and books the consequences of whatever is accepted.
    task automatic step(input logic s, input logic w, input logic [W-1:0] wd,
                        input logic r, input logic [W-1:0] ev,
                        output bit acc_w, output bit acc_r);
        int n;
        bit rdy;
        @(posedge clock);
        #1;
        n       = cyc;
        sclr    = s;
        wr_req  = w;
        wr_data = wd;
        rd_req  = r;
        rdy       = !s && (n >= ready_from);
        exp_ready = rdy;
        exp_en    = (n >= en_lo) && (n <= en_hi);
        exp_ext   = (n >= ext_lo) && (n <= ext_hi);
        exp_data  = data_model;
        started   = 1'b1;
        acc_w     = rdy && w;
        acc_r     = rdy && !w && r;
        if (s) begin
            ready_from = n + 1;
            en_lo = 1; en_hi = 0; ext_lo = 1; ext_hi = 0;
            data_model = 8'h00;
            while (rq.size() > 0 && rq[rq.size()-1].cyc > n) rq.delete(rq.size() - 1);
        end else if (acc_w) begin
            en_lo      = n + 1;
            en_hi      = n + WRC;
            data_model = wd;
            ready_from = n + 1 + WRC + TC;
        end else if (acc_r) begin
            ext_val    = ev;
            ext_lo     = n + 1;
            ext_hi     = n + RDW + TC;
            rq.push_back('{cyc: n + 1 + RDW, val: ev});
            ready_from = n + 1 + RDW + TC;
        end
    endtask

    task automatic idle(input int k);
        bit aw, ar;
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, aw, ar);
    endtask

    // Monitor: per-cycle output checks and scoreboard pops on rd_valid.
    initial begin : monitor
        logic         last_sclr;
        logic [W-1:0] rd_hold;
        last_sclr = 1'b0;
        rd_hold   = 8'h00;
        forever begin
            @(negedge clock);
            if (started && !done) begin
                if (last_sclr) rd_hold = 8'h00;
                check("ready", 32'(ready), 32'(exp_ready));
                check("enable", 32'(enable), 32'(exp_en));
                check("data", 32'(data), 32'(exp_data));
                if (exp_ext) check("turnaround_enable_low", 32'(enable), 32'd0);
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
                    check("rd_data_capture", 32'(rd_data), 32'(rq[0].val));
                    rd_hold = rq[0].val;
                    void'(rq.pop_front());
                end else begin
                    check("rd_valid_quiet", 32'(rd_valid), 32'd0);
                    check("rd_data_hold", 32'(rd_data), 32'(rd_hold));
                end
                last_sclr = sclr;
            end
        end
    end

    initial begin : stimulus
        bit aw, ar;
        // Reset for two cycles, then idle.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, aw, ar);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, aw, ar);
        idle(2);
        // Write 0xA5; a second write lands in the TURN cycle and is ignored.
        step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, aw, ar);
        idle(2);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, aw, ar);
        idle(2);
        // Read with the pad driven externally to 0x3C.
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, aw, ar);
        idle(5);
        // Simultaneous write and read: only the write happens.
        step(1'b0, 1'b1, 8'h77, 1'b1, 8'h99, aw, ar);
        idle(5);
        // Back-to-back write then a read held until accepted.
        step(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, aw, ar);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 8'h81, aw, ar);
            if (ar) break;
        end
        idle(5);
        // Clear during the second write cycle.
        step(1'b0, 1'b1, 8'hE1, 1'b0, 8'h00, aw, ar);
        idle(1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, aw, ar);
        idle(4);
        // Randomized traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), 8'($urandom()),
                 ($urandom_range(0, 2) == 0), 8'($urandom()), aw, ar);
        end
        idle(10);
        @(negedge clock);
        #1;
        done = 1'b1;
        check("scoreboard_drained", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
